// File: rtl/rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_arbiter
// Description : Arbitrates N_CH requesters onto the single RTC bus using a
//               req/ack handshake with a watchdog timeout, and returns read data.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_arbiter #(
    parameter int N_CH    = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          rd_wr_in,
    input  logic [N_CH*ADDR_W-1:0]   dir_in,
    input  logic [N_CH*DATA_W-1:0]   dato_in,
    output logic [N_CH-1:0]          gnt,
    output logic [N_CH-1:0]          done,
    output logic                     err,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     bus_req,
    output logic [ADDR_W-1:0]        dir_out,
    output logic [DATA_W-1:0]        dato,
    output logic                     RD_WR,
    input  logic                     bus_ack,
    input  logic [DATA_W-1:0]        dato_rtc
);

    localparam int c_ptr_w = $clog2(N_CH);
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(N_CH - 1);
    localparam logic [c_ptr_w:0]   c_n_ch     = (c_ptr_w + 1)'(N_CH);
    localparam logic [N_CH-1:0]    c_one      = N_CH'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] r_win;
    logic [c_cnt_w-1:0] r_cnt;
    logic [N_CH-1:0]    r_gnt;
    logic [N_CH-1:0]    r_done;
    logic               r_err;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_bus_req;
    logic [ADDR_W-1:0]  r_dir;
    logic [DATA_W-1:0]  r_dato;
    logic               r_rd_wr;

    logic [ADDR_W-1:0]  w_addr_arr [N_CH];
    logic [DATA_W-1:0]  w_data_arr [N_CH];

    logic               w_any;
    logic               w_found;
    logic [c_ptr_w-1:0] w_win;
    logic [c_ptr_w-1:0] w_base;
    logic [c_ptr_w:0]   w_sum;
    logic               w_load;
    logic               w_ack;
    logic               w_tmo;
    logic               w_finish;
    logic               w_release;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign w_addr_arr[i] = dir_in[i*ADDR_W +: ADDR_W];
        assign w_data_arr[i] = dato_in[i*DATA_W +: DATA_W];
    end

    // Search starts at the pointer and wraps; fixed priority simply starts at 0.
    always_comb begin
        w_any   = |req;
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_base  = (RR_MODE != 0) ? r_ptr : '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum = {1'b0, w_base} + (c_ptr_w + 1)'(k);
            if (w_sum >= c_n_ch) begin
                w_sum = w_sum - c_n_ch;
            end
            if (!w_found && req[w_sum[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_ptr_w-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_st_idle;
        case (r_state)
            c_st_idle:  w_next_state = w_any ? c_st_issue : c_st_idle;
            c_st_issue: w_next_state = (bus_ack || (r_cnt == c_cnt_last)) ? c_st_done : c_st_issue;
            c_st_done:  w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // An ack on the last watchdog cycle wins over the timeout.
    always_comb begin
        w_load    = (r_state == c_st_idle) && w_any;
        w_ack     = (r_state == c_st_issue) && bus_ack;
        w_tmo     = (r_state == c_st_issue) && !bus_ack && (r_cnt == c_cnt_last);
        w_finish  = w_ack || w_tmo;
        w_release = (r_state == c_st_done);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
            r_bus_req <= 1'b0;
            r_dir     <= '0;
            r_dato    <= '0;
            r_rd_wr   <= 1'b1;
        end else begin
            if (w_load) begin
                r_gnt     <= c_one << w_win;
                r_win     <= w_win;
                r_dir     <= w_addr_arr[w_win];
                r_dato    <= w_data_arr[w_win];
                r_rd_wr   <= rd_wr_in[w_win];
                r_bus_req <= 1'b1;
                r_cnt     <= '0;
            end
            if (r_state == c_st_issue) begin
                if (w_finish) begin
                    r_done    <= r_gnt;
                    r_err     <= w_tmo;
                    r_bus_req <= 1'b0;
                    if (w_ack && r_rd_wr) begin
                        r_rd_data <= dato_rtc;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_release) begin
                r_done <= '0;
                r_err  <= 1'b0;
                r_gnt  <= '0;
                if (RR_MODE != 0) begin
                    r_ptr <= (r_win == c_ptr_last) ? '0 : r_win + 1'b1;
                end
            end
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign rd_data = r_rd_data;
    assign bus_req = r_bus_req;
    assign dir_out = r_dir;
    assign dato    = r_dato;
    assign RD_WR   = r_rd_wr;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_bus_arbiter
// Description : Scoreboard bench running a round-robin and a fixed-priority
//               arbiter in lockstep against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_arbiter;

    localparam int N = 3;
    localparam int T = 8;

    typedef struct packed {
        logic [1:0][2:0] win;
        logic [1:0][7:0] dir;
        logic [1:0][7:0] dat;
        logic [1:0]      rw;
        logic [1:0][7:0] rd;
        logic            err;
        logic [7:0]      cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  rd_wr_in = '0;
    logic [23:0] dir_in = '0;
    logic [23:0] dato_in = '0;
    logic        bus_ack = 1'b0;
    logic [7:0]  dato_rtc = '0;

    logic [2:0]  gnt_o     [2];
    logic [2:0]  done_o    [2];
    logic        err_o     [2];
    logic [7:0]  rd_data_o [2];
    logic        bus_req_o [2];
    logic [7:0]  dir_out_o [2];
    logic [7:0]  dato_o    [2];
    logic        rd_wr_o   [2];

    int   checks = 0;
    int   failures = 0;
    exp_t q [$];
    int   mp = 0;
    logic [7:0] m_rd [2] = '{8'd0, 8'd0};
    int   cnt [2] = '{0, 0};
    logic pb [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    rtc_bus_arbiter #(.N_CH(N), .ADDR_W(8), .DATA_W(8), .RR_MODE(1), .TIMEOUT(T)) u_rr (
        .clk(clk), .reset(reset), .req(req), .rd_wr_in(rd_wr_in), .dir_in(dir_in),
        .dato_in(dato_in), .gnt(gnt_o[0]), .done(done_o[0]), .err(err_o[0]),
        .rd_data(rd_data_o[0]), .bus_req(bus_req_o[0]), .dir_out(dir_out_o[0]),
        .dato(dato_o[0]), .RD_WR(rd_wr_o[0]), .bus_ack(bus_ack), .dato_rtc(dato_rtc)
    );

    rtc_bus_arbiter #(.N_CH(N), .ADDR_W(8), .DATA_W(8), .RR_MODE(0), .TIMEOUT(T)) u_fp (
        .clk(clk), .reset(reset), .req(req), .rd_wr_in(rd_wr_in), .dir_in(dir_in),
        .dato_in(dato_in), .gnt(gnt_o[1]), .done(done_o[1]), .err(err_o[1]),
        .rd_data(rd_data_o[1]), .bus_req(bus_req_o[1]), .dir_out(dir_out_o[1]),
        .dato(dato_o[1]), .RD_WR(rd_wr_o[1]), .bus_ack(bus_ack), .dato_rtc(dato_rtc)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Winner by the arbitration rule: first requester at or after the start, wrapping.
    function automatic int pick(input logic [2:0] rq, input int start);
        int res;
        res = -1;
        for (int k = 0; k < N; k++) begin
            if (res < 0 && rq[(start + k) % N]) res = (start + k) % N;
        end
        return res;
    endfunction

    function automatic exp_t build(input logic [2:0] rq, input int d, input logic [7:0] ad);
        exp_t e;
        int   w;
        e = '0;
        for (int u = 0; u < 2; u++) begin
            w = pick(rq, (u == 0) ? mp : 0);
            e.win[u] = 3'(1 << w);
            e.dir[u] = dir_in[w*8 +: 8];
            e.dat[u] = dato_in[w*8 +: 8];
            e.rw[u]  = rd_wr_in[w];
            if (d < T && rd_wr_in[w]) m_rd[u] = ad;
            e.rd[u]  = m_rd[u];
            if (u == 0) mp = (w + 1) % N;
        end
        e.err = (d >= T);
        e.cyc = 8'((d < T) ? d + 1 : T);
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            if (bus_req_o[u] && !pb[u]) begin
                cnt[u] = 0;
                check($sformatf("issue_expected_%0d", u), 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q[0];
                    check($sformatf("issue_gnt_%0d", u), 32'(gnt_o[u]), 32'(e.win[u]));
                    check($sformatf("issue_dir_%0d", u), 32'(dir_out_o[u]), 32'(e.dir[u]));
                    check($sformatf("issue_dato_%0d", u), 32'(dato_o[u]), 32'(e.dat[u]));
                    check($sformatf("issue_rdwr_%0d", u), 32'(rd_wr_o[u]), 32'(e.rw[u]));
                end
            end
            if (bus_req_o[u]) cnt[u]++;
            pb[u] = bus_req_o[u];
            if (err_o[u] && done_o[u] == 3'b000)
                check($sformatf("err_without_done_%0d", u), 32'(err_o[u]), 32'd0);
        end
        if (done_o[0] != 3'b000 || done_o[1] != 3'b000) begin
            check("done_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int u = 0; u < 2; u++) begin
                    check($sformatf("done_%0d", u), 32'(done_o[u]), 32'(e.win[u]));
                    check($sformatf("done_gnt_%0d", u), 32'(gnt_o[u]), 32'(e.win[u]));
                    check($sformatf("err_%0d", u), 32'(err_o[u]), 32'(e.err));
                    check($sformatf("rd_data_%0d", u), 32'(rd_data_o[u]), 32'(e.rd[u]));
                    check($sformatf("bus_cycles_%0d", u), 32'(cnt[u]), 32'(e.cyc));
                end
            end
        end
    end

    task automatic rand_inputs();
        rd_wr_in = 3'($urandom);
        dir_in   = 24'($urandom);
        dato_in  = 24'($urandom);
    endtask

    task automatic wait_bus(output bit ok);
        ok = 1'b0;
        for (int j = 0; j < 4 && !ok; j++) begin
            @(negedge clk);
            ok = bus_req_o[0] | bus_req_o[1];
        end
        check("bus_req_start", 32'(ok), 32'd1);
    endtask

    // Ack is sampled at the edge after negedge j == d; d >= T never acks in ISSUE.
    task automatic run_txn(input logic [2:0] rq, input int d);
        logic [7:0] ad;
        bit ok;
        bit dropped;
        ad = 8'($urandom);
        q.push_back(build(rq, d, ad));
        req = rq;
        wait_bus(ok);
        if (!ok) begin
            req = '0;
            return;
        end
        dropped = 1'b0;
        for (int j = 0; j < T + 4; j++) begin
            bus_ack  = (j == d);
            dato_rtc = (j == d) ? ad : 8'($urandom);
            if ((done_o[0] | done_o[1]) != 3'b000) begin
                dropped = 1'b1;
                req = '0;
            end
            if (dropped && j > d) break;
            @(negedge clk);
        end
        bus_ack = 1'b0;
        check("done_seen", 32'(dropped), 32'd1);
    endtask

    initial begin : stim
        bit ok;
        reset = 1'b0;
        req   = 3'b111;
        rand_inputs();
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst_gnt_%0d", u), 32'(gnt_o[u]), 32'd0);
            check($sformatf("rst_bus_req_%0d", u), 32'(bus_req_o[u]), 32'd0);
            check($sformatf("rst_rdwr_%0d", u), 32'(rd_wr_o[u]), 32'd1);
            check($sformatf("rst_dir_%0d", u), 32'(dir_out_o[u]), 32'd0);
            check($sformatf("rst_dato_%0d", u), 32'(dato_o[u]), 32'd0);
            check($sformatf("rst_done_%0d", u), 32'(done_o[u]), 32'd0);
            check($sformatf("rst_err_%0d", u), 32'(err_o[u]), 32'd0);
            check($sformatf("rst_rd_data_%0d", u), 32'(rd_data_o[u]), 32'd0);
        end
        reset = 1'b1;

        // All channels requesting: round-robin order 0,1,2,0 from reset.
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            if (i == 2) begin
                dir_in[23:16]  = 8'h22;
                dato_in[23:16] = 8'h30;
                rd_wr_in[2]    = 1'b0;
            end
            run_txn(3'b111, int'($urandom_range(0, 4)));
        end

        rand_inputs();
        dir_in[15:8] = 8'h21;
        rd_wr_in[1]  = 1'b1;
        run_txn(3'b010, 3);

        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            run_txn((i < 3) ? 3'b110 : 3'b100, int'($urandom_range(0, 3)));
        end

        rand_inputs();
        run_txn(3'b011, T);
        rand_inputs();
        run_txn(3'b101, T + 1);
        rand_inputs();
        run_txn(3'b111, T - 1);

        for (int i = 0; i < 30; i++) begin
            rand_inputs();
            run_txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 10)));
        end

        // Abort mid-ISSUE: no done pulse, pointer and read data back to reset.
        rand_inputs();
        q.push_back(build(3'b001, 20, 8'h00));
        req = 3'b001;
        wait_bus(ok);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req   = '0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("abort_bus_req_%0d", u), 32'(bus_req_o[u]), 32'd0);
            check($sformatf("abort_gnt_%0d", u), 32'(gnt_o[u]), 32'd0);
            check($sformatf("abort_done_%0d", u), 32'(done_o[u]), 32'd0);
        end
        reset = 1'b1;
        q.delete();
        mp   = 0;
        m_rd = '{8'd0, 8'd0};

        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            run_txn((i == 0) ? 3'b101 : 3'($urandom_range(1, 7)), int'($urandom_range(0, 9)));
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
